nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_add4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // At least one bit, so a single-nibble adder still has an index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// Combinational 4-bit ripple slice; c3 is the carry into bit 3.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
  end

  assign s    = a ^ b ^ c[3:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built by streaming nibbles LSB-first through one 4-bit slice.
// Optional macro SNA_OVERFLOW_EN adds the signed-overflow output ovf.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
`ifdef SNA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;

  logic [3:0] na;
  logic [3:0] nb;
  logic [3:0] ns;
  logic       nc;
`ifdef SNA_OVERFLOW_EN
  logic       n3;
`else
  logic       c3_unused;
`endif

  assign last = (idx == LAST);
  assign na   = op_a[idx*NIBBLE_W +: NIBBLE_W];
  assign nb   = op_b[idx*NIBBLE_W +: NIBBLE_W];

  nibble_add4 u_add4 (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .s    (ns),
    .cout (nc),
`ifdef SNA_OVERFLOW_EN
    .c3   (n3)
`else
    .c3   (c3_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
`ifdef SNA_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= ns;
          carry <= nc;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum[WIDTH] <= nc;
`ifdef SNA_OVERFLOW_EN
            ovf <= n3 ^ nc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: vector table, scoreboard queue, stall and abort sequences.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;
`ifdef SNA_OVERFLOW_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
`ifdef SNA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   sum;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W:0] sum;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Independent reference: plain wide addition and sign-bit overflow rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    e.sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    return e;
  endfunction

  // Assumes it is called #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input int hold, input bit keep_valid);
    exp_t       e;
    int         cyc;
    logic [W:0] s0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(ta, tb, tc));
    #1;
    in_valid = keep_valid;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", 32'(cyc), 32'(NIB));
    check("in_ready_done", 32'(in_ready), 32'd0);
    s0 = sum;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_sum", 32'(sum), 32'(s0));
      check("hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sum", 32'(sum), 32'(e.sum));
`ifdef SNA_OVERFLOW_EN
      check("ovf", 32'(ovf), 32'(e.ovf));
`endif
    end else begin
      check("sb_empty", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  vec_t vt[8];
  int   cyc;

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0};
    vt[6] = '{16'hABCD, 16'h1111, 1'b0, 17'h0BCDE, 1'b0};
    vt[7] = '{16'h0F0F, 16'h00F1, 1'b0, 17'h01000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors: the table's expected sums must agree with the model.
    for (int i = 0; i < 8; i++) begin
      exp_t m;
      m = model(vt[i].a, vt[i].b, vt[i].cin);
      check("table_model", {15'd0, m.ovf, m.sum}, {15'd0, vt[i].ovf, vt[i].sum});
      run_op(vt[i].a, vt[i].b, vt[i].cin, i % 2, 1'b0);
    end

    // Long stall in DONE with in_valid held high throughout.
    run_op(16'h1234, 16'h4321, 1'b0, 5, 1'b1);

    // Abort mid-RUN: reset two cycles after the accept edge.
    @(posedge clk); #1;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("abort_sum", 32'(sum), 32'd0);
    cyc = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) cyc++;
    end
    check("abort_no_valid", 32'(cyc), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // Random operands, checked through the scoreboard against the model.
    for (int i = 0; i < 10; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
